// File: rtl/axis_deadlock_monitor_mc_if.sv
// Signal bundle between a deadlock monitor and its bench-side driver.
// master drives the block/idle flags and clear; slave is the monitor itself.
interface axis_deadlock_monitor_mc_if #(
  parameter int unsigned NUM_AXIS = 4,
  parameter int unsigned NUM_INST = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
);
  logic                clear;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic [NUM_AXIS-1:0] axis_block_info;
  logic                block;
  logic [IDX_W-1:0]    first_axis_idx;
  logic [CNT_W-1:0]    block_cycles;

  modport master (
    output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  axis_block_info, block, first_axis_idx, block_cycles
  );

  modport slave (
    input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output axis_block_info, block, first_axis_idx, block_cycles
  );
endinterface

// File: rtl/axis_deadlock_monitor_mc.sv
// Multi-channel deadlock monitor: declares block after HOLD_CYCLES consecutive stalled cycles.
// Define DEADLOCK_MON_STICKY_EN to make the BLOCKED state hold until clear or reset.
module axis_deadlock_monitor_mc #(
  parameter int unsigned NUM_AXIS    = 4,
  parameter int unsigned NUM_INST    = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDX_W       = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input logic                       clock,
  input logic                       reset,
  axis_deadlock_monitor_mc_if.slave mon
);

  typedef enum logic [1:0] {StIdle, StSuspect, StBlocked} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Hold   = CNT_W'(HOLD_CYCLES);

  state_e              state_q, state_d;
  logic                block_q, block_d;
  logic [NUM_AXIS-1:0] info_q, info_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                axis_any;
  logic                inst_term;
  logic                cond;
  logic [IDX_W-1:0]    low_idx;
  logic [CNT_W-1:0]    cnt_inc;

  // Instance term needs every instance quiet (idle or blocked) and at least one blocked.
  assign axis_any  = |mon.axis_block_sigs;
  assign inst_term = (&(mon.inst_block_sigs | mon.inst_idle_sigs)) & (|mon.inst_block_sigs);
  assign cond      = axis_any | inst_term;

  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_AXIS) - 1; i >= 0; i--) begin
      if (mon.axis_block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    block_d = block_q;
    info_d  = info_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    if (mon.clear) begin
      state_d = StIdle;
      block_d = 1'b0;
      info_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          block_d = 1'b0;
          info_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          if (cond) begin
            cnt_d = CNT_W'(1);
            idx_d = low_idx;
            if (HOLD_CYCLES == 1) begin
              state_d = StBlocked;
              block_d = 1'b1;
              info_d  = mon.axis_block_sigs;
            end else begin
              state_d = StSuspect;
            end
          end
        end

        StSuspect: begin
          if (cond) begin
            cnt_d = cnt_inc;
            if (cnt_inc == Hold) begin
              state_d = StBlocked;
              block_d = 1'b1;
              info_d  = mon.axis_block_sigs;
            end
          end else begin
            // A single dropped cycle forfeits all accumulated credit.
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end

        StBlocked: begin
          if (cond) begin
            cnt_d  = cnt_inc;
            info_d = info_q | mon.axis_block_sigs;
          end else begin
`ifdef DEADLOCK_MON_STICKY_EN
            // Hold everything; the count pauses until cond returns.
            cnt_d = cnt_q;
`else
            state_d = StIdle;
            block_d = 1'b0;
            info_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
`endif
          end
        end

        default: begin
          state_d = StIdle;
          block_d = 1'b0;
          info_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      block_q <= 1'b0;
      info_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      info_q  <= info_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mon.block           = block_q;
  assign mon.axis_block_info = info_q;
  assign mon.first_axis_idx  = idx_q;
  assign mon.block_cycles    = cnt_q;

  a_block_matches_state: assert property (
    @(posedge clock) disable iff (reset) block_q == (state_q == StBlocked));
  a_info_zero_unblocked: assert property (
    @(posedge clock) disable iff (reset) !block_q |-> (info_q == '0));
  a_idle_is_quiet: assert property (
    @(posedge clock) disable iff (reset) (state_q == StIdle) |-> (cnt_q == '0 && idx_q == '0));

endmodule

// File: tb/tb_axis_deadlock_monitor_mc.sv
// Table-driven bench for axis_deadlock_monitor_mc over three configurations.
// Expectations adapt to DEADLOCK_MON_STICKY_EN when it is defined.
module tb_axis_deadlock_monitor_mc;

`ifdef DEADLOCK_MON_STICKY_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  typedef struct {
    int         dut;
    bit         rst;
    bit         clr;
    logic [3:0] axis;
    logic [1:0] idle;
    logic [1:0] blk;
    bit         eb;
    logic [3:0] einfo;
    logic [1:0] eidx;
    logic [7:0] ecyc;
  } vec_t;

  logic clock;
  logic reset;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec;
  int   n_err;

  // dut0: HOLD=4, CNT_W=8.  dut1: HOLD=2, CNT_W=4.  dut2: HOLD=1, CNT_W=8.
  axis_deadlock_monitor_mc_if #(.NUM_AXIS(4), .NUM_INST(2), .CNT_W(8)) if0 ();
  axis_deadlock_monitor_mc_if #(.NUM_AXIS(4), .NUM_INST(2), .CNT_W(4)) if1 ();
  axis_deadlock_monitor_mc_if #(.NUM_AXIS(4), .NUM_INST(2), .CNT_W(8)) if2 ();

  axis_deadlock_monitor_mc #(
    .NUM_AXIS(4), .NUM_INST(2), .HOLD_CYCLES(4), .CNT_W(8)
  ) u_dut0 (.clock(clock), .reset(reset), .mon(if0));

  axis_deadlock_monitor_mc #(
    .NUM_AXIS(4), .NUM_INST(2), .HOLD_CYCLES(2), .CNT_W(4)
  ) u_dut1 (.clock(clock), .reset(reset), .mon(if1));

  axis_deadlock_monitor_mc #(
    .NUM_AXIS(4), .NUM_INST(2), .HOLD_CYCLES(1), .CNT_W(8)
  ) u_dut2 (.clock(clock), .reset(reset), .mon(if2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(int dut, int rst, int clr, int axis, int idle, int blk,
                              int eb, int einfo, int eidx, int ecyc);
    vec_t v;
    v.dut   = dut;
    v.rst   = rst[0];
    v.clr   = clr[0];
    v.axis  = axis[3:0];
    v.idle  = idle[1:0];
    v.blk   = blk[1:0];
    v.eb    = eb[0];
    v.einfo = einfo[3:0];
    v.eidx  = eidx[1:0];
    v.ecyc  = ecyc[7:0];
    vecs.push_back(v);
  endfunction

  // Expected outputs when cond drops while BLOCKED: held values if sticky, else all zero.
  function automatic void add_drop(int dut, int axis, int idle, int blk,
                                   int einfo, int eidx, int ecyc);
    if (Sticky) add(dut, 0, 0, axis, idle, blk, 1, einfo, eidx, ecyc);
    else        add(dut, 0, 0, axis, idle, blk, 0, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    reset                 = v.rst;
    if0.clear             = (v.dut == 0) && v.clr;
    if0.axis_block_sigs   = (v.dut == 0) ? v.axis : 4'h0;
    if0.inst_idle_sigs    = (v.dut == 0) ? v.idle : 2'b00;
    if0.inst_block_sigs   = (v.dut == 0) ? v.blk  : 2'b00;
    if1.clear             = (v.dut == 1) && v.clr;
    if1.axis_block_sigs   = (v.dut == 1) ? v.axis : 4'h0;
    if1.inst_idle_sigs    = (v.dut == 1) ? v.idle : 2'b00;
    if1.inst_block_sigs   = (v.dut == 1) ? v.blk  : 2'b00;
    if2.clear             = (v.dut == 2) && v.clr;
    if2.axis_block_sigs   = (v.dut == 2) ? v.axis : 4'h0;
    if2.inst_idle_sigs    = (v.dut == 2) ? v.idle : 2'b00;
    if2.inst_block_sigs   = (v.dut == 2) ? v.blk  : 2'b00;
  endtask

  task automatic check(input vec_t e, input int idx);
    logic       a_b;
    logic [3:0] a_info;
    logic [1:0] a_idx;
    logic [7:0] a_cyc;
    case (e.dut)
      0: begin
        a_b = if0.block; a_info = if0.axis_block_info;
        a_idx = if0.first_axis_idx; a_cyc = if0.block_cycles;
      end
      1: begin
        a_b = if1.block; a_info = if1.axis_block_info;
        a_idx = if1.first_axis_idx; a_cyc = {4'h0, if1.block_cycles};
      end
      default: begin
        a_b = if2.block; a_info = if2.axis_block_info;
        a_idx = if2.first_axis_idx; a_cyc = if2.block_cycles;
      end
    endcase
    n_vec++;
    if (a_b !== e.eb || a_info !== e.einfo || a_idx !== e.eidx || a_cyc !== e.ecyc) begin
      n_err++;
      $display("FAIL vec%0d dut%0d: block/info/idx/cycles got %0b/%b/%0d/%0d want %0b/%b/%0d/%0d",
               idx, e.dut, a_b, a_info, a_idx, a_cyc, e.eb, e.einfo, e.eidx, e.ecyc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    if0.clear = 1'b0; if0.axis_block_sigs = '0; if0.inst_idle_sigs = '0; if0.inst_block_sigs = '0;
    if1.clear = 1'b0; if1.axis_block_sigs = '0; if1.inst_idle_sigs = '0; if1.inst_block_sigs = '0;
    if2.clear = 1'b0; if2.axis_block_sigs = '0; if2.inst_idle_sigs = '0; if2.inst_block_sigs = '0;

    // Reset state of all three instances.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Axis 2 held: block after the fourth edge, then drop and clear.
    add(0, 0, 0, 4'b0100, 0, 0, 0, 0, 2, 1);
    add(0, 0, 0, 4'b0100, 0, 0, 0, 0, 2, 2);
    add(0, 0, 0, 4'b0100, 0, 0, 0, 0, 2, 3);
    add(0, 0, 0, 4'b0100, 0, 0, 1, 4'b0100, 2, 4);
    add(0, 0, 0, 4'b0100, 0, 0, 1, 4'b0100, 2, 5);
    add_drop(0, 0, 0, 0, 4'b0100, 2, 5);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Accumulate axis 1 then axis 3 while BLOCKED.
    add(0, 0, 0, 4'b0010, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 4'b0010, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 4'b0010, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 4'b0010, 0, 0, 1, 4'b0010, 1, 4);
    add(0, 0, 0, 4'b1000, 0, 0, 1, 4'b1010, 1, 5);
    add_drop(0, 0, 0, 0, 4'b1010, 1, 5);
    add_drop(0, 0, 0, 0, 4'b1010, 1, 5);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // One-cycle gap in SUSPECT restarts the count.
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 0, 4);
    add_drop(0, 0, 0, 0, 4'b0001, 0, 4);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Lowest set index wins; clear beats cond and re-arms from IDLE.
    add(0, 0, 0, 4'b1100, 0, 0, 0, 0, 2, 1);
    add(0, 0, 1, 4'b1100, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'b1100, 0, 0, 0, 0, 2, 1);
    add(0, 0, 0, 4'b1100, 0, 0, 0, 0, 2, 2);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    // Instance-only deadlock; all-idle is not a deadlock.
    add(0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1);
    add(0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 2);
    add(0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 3);
    add(0, 0, 0, 0, 2'b01, 2'b10, 1, 0, 0, 4);
    add_drop(0, 0, 2'b00, 2'b10, 0, 0, 4);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 1);
    add(0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0);

    // CNT_W=4, HOLD=2: saturate at 15, then reset mid-deadlock.
    for (int n = 1; n <= 40; n++) begin
      add(1, 0, 0, 4'b0001, 0, 0, (n >= 2) ? 1 : 0, (n >= 2) ? 1 : 0, 0, (n < 15) ? n : 15);
    end
    add(1, 1, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);

    // HOLD=1: single-cycle pulse, then clear coinciding with cond.
    add(2, 0, 0, 4'b0100, 0, 0, 1, 4'b0100, 2, 1);
    add_drop(2, 0, 0, 0, 4'b0100, 2, 1);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 4'b0100, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 4'b1000, 0, 0, 1, 4'b1000, 3, 1);
    add(2, 0, 0, 4'b0010, 0, 0, 1, 4'b1010, 3, 2);
    add(2, 0, 1, 4'b0010, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(posedge clock);
      #1;
      check(exp_q.pop_front(), i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
